// File: rtl/irq_ctrl.sv
// irq_ctrl: sticky, maskable interrupt controller with per-source
// level/rising-edge detection and a software-acknowledge hold-off.
// Configured through a simple word-addressed register bus.
//
// Optional feature: define IRQ_CTRL_IRQ_COUNT_EN to add a saturating
// 16-bit count of INTERRUPT rising transitions at word address 4.
// Without it, address 4 reads 0 and ignores writes.
module irq_ctrl #(
  parameter int unsigned N_SRC     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [N_SRC-1:0] EVENT,
  input  logic             REG_WE,
  input  logic             REG_RE,
  input  logic [2:0]       REG_ADDR,
  input  logic [31:0]      REG_WDATA,
  output logic [31:0]      REG_RDATA,
  output logic             REG_RVALID,
  output logic             INTERRUPT
);

  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_ENABLE    = 3'd1;
  localparam logic [2:0] ADDR_MODE      = 3'd2;
  localparam logic [2:0] ADDR_HOLDOFF   = 3'd3;
  localparam logic [2:0] ADDR_IRQ_COUNT = 3'd4;

  logic [N_SRC-1:0]     status;
  logic [N_SRC-1:0]     enable;
  logic [N_SRC-1:0]     mode;
  logic [N_SRC-1:0]     event_q;
  logic [CNT_WIDTH-1:0] holdoff;
  logic [CNT_WIDTH-1:0] holdoff_cnt;

  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic             wr_status;
  logic             ack_load;
  logic             irq_next;
  logic [31:0]      rd_word;

  // Only the low N_SRC / CNT_WIDTH write-data bits are stored; the rest
  // are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^REG_WDATA;

  // Edge sources pend on a 0->1 step, level sources on every high cycle.
  assign set_vec   = (mode & EVENT & ~event_q) | (~mode & EVENT);
  assign wr_status = REG_WE && (REG_ADDR == ADDR_STATUS);
  assign clr_vec   = wr_status ? REG_WDATA[N_SRC-1:0] : '0;
  // Only an acknowledge that actually names a source starts the hold-off.
  assign ack_load  = wr_status && (|REG_WDATA[N_SRC-1:0]);
  assign irq_next  = (|(status & enable)) && (holdoff_cnt == '0);

`ifdef IRQ_CTRL_IRQ_COUNT_EN
  logic [15:0] irq_count;

  // Count INTERRUPT rising transitions; a software write clears and wins.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      irq_count <= '0;
    end else if (REG_WE && (REG_ADDR == ADDR_IRQ_COUNT)) begin
      irq_count <= '0;
    end else if (irq_next && !INTERRUPT && (irq_count != 16'hFFFF)) begin
      irq_count <= irq_count + 16'd1;
    end
  end
`endif

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // rd_word unassigned, which would infer a latch.
    rd_word = '0;
    case (REG_ADDR)
      ADDR_STATUS:    rd_word = 32'(status);
      ADDR_ENABLE:    rd_word = 32'(enable);
      ADDR_MODE:      rd_word = 32'(mode);
      ADDR_HOLDOFF:   rd_word = 32'(holdoff);
`ifdef IRQ_CTRL_IRQ_COUNT_EN
      ADDR_IRQ_COUNT: rd_word = 32'(irq_count);
`else
      ADDR_IRQ_COUNT: rd_word = '0;
`endif
      default:        rd_word = '0;
    endcase
  end

  // Detection, pending/config registers, hold-off counter and bus outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      event_q     <= '0;
      status      <= '0;
      enable      <= '0;
      mode        <= '0;
      holdoff     <= '0;
      holdoff_cnt <= '0;
      INTERRUPT   <= 1'b0;
      REG_RDATA   <= '0;
      REG_RVALID  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; this is what makes a same-cycle read return the
      // pre-write contents.
      event_q <= EVENT;
      // Set is OR-ed after the clear mask so a coincident set wins.
      status  <= (status & ~clr_vec) | set_vec;

      if (REG_WE && (REG_ADDR == ADDR_ENABLE))  enable  <= REG_WDATA[N_SRC-1:0];
      if (REG_WE && (REG_ADDR == ADDR_MODE))    mode    <= REG_WDATA[N_SRC-1:0];
      if (REG_WE && (REG_ADDR == ADDR_HOLDOFF)) holdoff <= REG_WDATA[CNT_WIDTH-1:0];

      if (ack_load) begin
        holdoff_cnt <= holdoff;
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - CNT_WIDTH'(1);
      end

      INTERRUPT  <= irq_next;

      REG_RVALID <= REG_RE;
      if (REG_RE) REG_RDATA <= rd_word;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (default N_SRC=8, CNT_WIDTH=8).
// Register reads push their expected value into a scoreboard queue; a
// monitor pops and compares whenever REG_RVALID is seen. INTERRUPT and
// other outputs are checked directly, 1 ns after the rising edge.
module tb_irq_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  EVENT = '0;
  logic        REG_WE = 1'b0;
  logic        REG_RE = 1'b0;
  logic [2:0]  REG_ADDR = '0;
  logic [31:0] REG_WDATA = '0;
  logic [31:0] REG_RDATA;
  logic        REG_RVALID;
  logic        INTERRUPT;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  irq_ctrl #(.N_SRC(8), .CNT_WIDTH(8)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .EVENT     (EVENT),
    .REG_WE    (REG_WE),
    .REG_RE    (REG_RE),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .REG_RDATA (REG_RDATA),
    .REG_RVALID(REG_RVALID),
    .INTERRUPT (INTERRUPT)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Read-data scoreboard: one expected entry per REG_RVALID pulse.
  always @(negedge ACLK) begin
    if (REG_RVALID) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rvalid_extra: got REG_RVALID=1, expected no pending read");
      end else begin
        check(name_q.pop_front(), REG_RDATA, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
    REG_WE    = 1'b1;
    REG_ADDR  = addr;
    REG_WDATA = data;
    tick();
    REG_WE    = 1'b0;
    REG_WDATA = '0;
  endtask

  task automatic reg_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    REG_RE   = 1'b1;
    REG_ADDR = addr;
    tick();
    REG_RE   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reg_vec_t vecs[10];

    // Config read/write vectors: write, then read back the masked value.
    vecs[0] = '{3'd0, 32'h0000_00FF, 32'h0000_0000};  // W1C with nothing pending
    vecs[1] = '{3'd1, 32'hFFFF_FF5A, 32'h0000_005A};
    vecs[2] = '{3'd2, 32'h1234_00C3, 32'h0000_00C3};
    vecs[3] = '{3'd3, 32'h0000_ABCD, 32'h0000_00CD};
    vecs[4] = '{3'd4, 32'h0000_FFFF, 32'h0000_0000};
    vecs[5] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{3'd3, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{3'd1, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{3'd2, 32'hFFFF_FF00, 32'h0000_0000};

    // ---- Reset state ----
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_interrupt", 32'(INTERRUPT), 32'd0);
    check("rst_rvalid", 32'(REG_RVALID), 32'd0);
    check("rst_rdata", REG_RDATA, 32'd0);
    ARESETn = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) reg_read(3'(a), 32'd0, $sformatf("rst_read_a%0d", a));
    tick();
    check("rst_interrupt_after_reads", 32'(INTERRUPT), 32'd0);

    // ---- Table-driven register access ----
    for (int i = 0; i < 10; i++) begin
      reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_a%0d", i, vecs[i].addr));
    end

    // ---- Level pulse -> STATUS -> INTERRUPT latency, then W1C ----
    reg_write(3'd1, 32'h01);
    EVENT = 8'h01;
    tick();                               // edge k samples the event
    EVENT = 8'h00;
    check("irq_low_after_k", 32'(INTERRUPT), 32'd0);
    tick();
    check("irq_high_after_k1", 32'(INTERRUPT), 32'd1);
    repeat (3) tick();
    check("irq_sticky", 32'(INTERRUPT), 32'd1);
    reg_read(3'd0, 32'h01, "status_pulse");
    reg_write(3'd0, 32'h01);
    check("irq_still_high_at_w1c", 32'(INTERRUPT), 32'd1);
    tick();
    check("irq_low_after_w1c", 32'(INTERRUPT), 32'd0);

    // ---- Edge vs level detection with held EVENT ----
    reg_write(3'd2, 32'hFF);
    EVENT = 8'h08;
    repeat (10) tick();
    reg_read(3'd0, 32'h08, "edge_status_set");
    reg_write(3'd0, 32'h08);
    reg_read(3'd0, 32'h00, "edge_w1c_while_high");
    EVENT = 8'h00;
    tick();
    reg_write(3'd2, 32'h00);
    EVENT = 8'h08;
    repeat (2) tick();
    reg_write(3'd0, 32'h08);
    reg_read(3'd0, 32'h08, "level_repend");
    EVENT = 8'h00;
    reg_write(3'd0, 32'h08);
    reg_read(3'd0, 32'h00, "level_cleared");

    // ---- Hold-off ----
    reg_write(3'd3, 32'd5);
    reg_write(3'd1, 32'hFF);
    EVENT = 8'h04;
    repeat (2) tick();
    check("holdoff_irq_pre", 32'(INTERRUPT), 32'd1);
    reg_write(3'd0, 32'h04);              // loads counter with 5
    check("holdoff_irq_at_load", 32'(INTERRUPT), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("holdoff_low_c%0d", c), 32'(INTERRUPT), 32'd0);
    end
    tick();
    check("holdoff_high_again", 32'(INTERRUPT), 32'd1);
    reg_write(3'd3, 32'd0);
    reg_write(3'd0, 32'h04);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("holdoff0_high_c%0d", c), 32'(INTERRUPT), 32'd1);
      tick();
    end
    EVENT = 8'h00;
    reg_write(3'd0, 32'hFF);
    reg_write(3'd1, 32'h00);

    // ---- Set beats clear in the same cycle ----
    reg_write(3'd2, 32'h02);
    EVENT = 8'h02;
    tick();
    EVENT = 8'h00;
    tick();
    EVENT = 8'h02;                        // new edge coincides with the W1C
    reg_write(3'd0, 32'h02);
    EVENT = 8'h00;
    reg_read(3'd0, 32'h02, "set_wins_over_clear");
    reg_write(3'd0, 32'h02);
    reg_read(3'd0, 32'h00, "clear_after_set");
    reg_write(3'd2, 32'h00);

    // ---- Same-cycle read and write returns pre-write value ----
    exp_q.push_back(32'h00);
    name_q.push_back("rw_same_cycle_old");
    REG_WE = 1'b1; REG_RE = 1'b1; REG_ADDR = 3'd1; REG_WDATA = 32'hAA;
    tick();
    REG_WE = 1'b0; REG_RE = 1'b0; REG_WDATA = '0;
    reg_read(3'd1, 32'hAA, "rw_same_cycle_new");
    tick();
    check("rvalid_one_cycle", 32'(REG_RVALID), 32'd0);
    check("rdata_holds", REG_RDATA, 32'hAA);
    reg_write(3'd1, 32'h00);

`ifdef IRQ_CTRL_IRQ_COUNT_EN
    // ---- Interrupt transition counter ----
    reg_write(3'd1, 32'h01);
    reg_write(3'd4, 32'h0);
    for (int n = 0; n < 3; n++) begin
      EVENT = 8'h01;
      tick();
      EVENT = 8'h00;
      tick();
      reg_write(3'd0, 32'h01);
      tick();
    end
    reg_read(3'd4, 32'd3, "irq_count_3");
    reg_write(3'd4, 32'h0);
    reg_read(3'd4, 32'd0, "irq_count_cleared");
    reg_write(3'd1, 32'h00);
`endif

    // ---- Reset in the middle of a hold-off ----
    reg_write(3'd1, 32'h01);
    reg_write(3'd3, 32'd20);
    EVENT = 8'h01;
    repeat (2) tick();
    reg_write(3'd0, 32'h01);
    repeat (3) tick();
    check("midholdoff_irq_low", 32'(INTERRUPT), 32'd0);
    reg_read(3'd3, 32'd20, "midholdoff_holdoff");
    tick();
    #2;
    ARESETn = 1'b0;
    EVENT   = 8'h00;
    #1;
    check("async_rst_rdata", REG_RDATA, 32'd0);
    check("async_rst_interrupt", 32'(INTERRUPT), 32'd0);
    check("async_rst_rvalid", 32'(REG_RVALID), 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    tick();
    reg_read(3'd0, 32'd0, "post_rst_status");
    reg_read(3'd1, 32'd0, "post_rst_enable");
    reg_read(3'd3, 32'd0, "post_rst_holdoff");
    reg_read(3'd4, 32'd0, "post_rst_addr4");
    reg_write(3'd1, 32'h01);
    EVENT = 8'h01;
    tick();
    EVENT = 8'h00;
    tick();
    check("post_rst_no_holdoff", 32'(INTERRUPT), 32'd1);
    reg_write(3'd0, 32'h01);
    reg_write(3'd1, 32'h00);

    // Drain outstanding reads with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("reads_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller that drives the FPGA INTERRUPT line presented on the AXI4 register slot.
- Collects N_SRC event inputs into sticky, maskable pending bits, with level or edge detection per source.
- Applies a programmable hold-off after software acknowledges, so the PS is not re-interrupted immediately.
- Configured through the simple word-addressed register bus that the AXI4-Lite slave decoder already produces inside the FPGA.

Parameters:
N_SRC, 8, number of event sources (1..32)
CNT_WIDTH, 8, width of the HOLDOFF register and hold-off counter (1..32)

Ports:
ACLK  input  1  sole clock, rising edge
ARESETn  input  1  asynchronous active-low reset
EVENT  input  N_SRC  event sources, synchronous to ACLK
REG_WE  input  1  register write strobe, one cycle per write
REG_RE  input  1  register read strobe, one cycle per read
REG_ADDR  input  3  word address
REG_WDATA  input  32  write data
REG_RDATA  output  32  read data
REG_RVALID  output  1  read data valid pulse
INTERRUPT  output  1  level interrupt to PS, registered

Behaviour:
- Clock and reset: one clock, ACLK; reset ARESETn is asynchronous assert, active-low. All flops clear on reset.
- Reset values: REG_RDATA=0, REG_RVALID=0, INTERRUPT=0; STATUS, ENABLE, MODE, HOLDOFF, hold-off counter and event_q all 0.
- Register map (word address); bits at and above N_SRC (or CNT_WIDTH for HOLDOFF) read 0 and ignore writes:
  - 0 STATUS: sticky pending bits. Write-1-to-clear; write-0 has no effect.
  - 1 ENABLE: per-source mask, read/write.
  - 2 MODE: per-source detection, read/write; 1 = rising edge, 0 = level.
  - 3 HOLDOFF: hold-off length in cycles, read/write.
  - 4 IRQ_COUNT: see Optional Feature.
  - 5..7: read 0, writes ignored.
- Detection:
  - event_q <= EVENT every cycle.
  - set[i] = MODE[i] ? (EVENT[i] & ~event_q[i]) : EVENT[i].
  - STATUS[i] is set on the edge where set[i]=1. Pending latches regardless of ENABLE.
  - An EVENT held high through reset counts as an edge on the first post-reset cycle.
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
  - Consequence: a level source still high re-pends immediately.
- Hold-off counter:
  - Any STATUS write with at least one REG_WDATA bit 1 within N_SRC loads the counter with HOLDOFF.
  - Otherwise the counter decrements while nonzero and stops at 0.
  - HOLDOFF=0 means no hold-off.
  - Writing HOLDOFF does not disturb a running count.
- INTERRUPT <= (|(STATUS & ENABLE)) & (holdoff_cnt==0), registered.
  - Latency: EVENT sampled high at edge k -> STATUS=1 after edge k -> INTERRUPT=1 after edge k+1.
  - Clearing ENABLE or STATUS drops INTERRUPT one edge after the register updates.
- Read timing:
  - REG_RE at edge k -> REG_RDATA valid and REG_RVALID=1 for exactly one cycle after edge k.
  - REG_RDATA holds its last value otherwise.
  - Reading has no side effects.
- REG_RE and REG_WE in the same cycle (any addresses): the write is performed, and the read returns the pre-write value.

Optional Feature:
- Macro IRQ_CTRL_IRQ_COUNT_EN.
- Defined:
  - Address 4 is a 16-bit count of INTERRUPT 0->1 transitions, saturating at 0xFFFF, read in bits [15:0] (upper bits 0).
  - Any write to address 4 clears it.
  - If a write and an increment coincide, the clear wins.
- Undefined: address 4 reads 0, writes are ignored, and no counter logic is present.

Test Plan:
- Reset with EVENT=0, then read all 8 addresses -> every read returns 0; INTERRUPT=0; REG_RVALID pulses once per REG_RE.
- ENABLE=0x01, MODE=0, pulse EVENT[0] for 1 cycle at edge k -> STATUS=0x01, INTERRUPT=1 after edge k+1 and stays 1; write STATUS=0x01 -> INTERRUPT=0 two edges later.
- MODE=0xFF, EVENT[3] held high 10 cycles -> STATUS=0x08 set once; W1C 0x08 while EVENT[3] still high -> STATUS=0; level mode with the same stimulus -> STATUS reads 0x08 after the W1C.
- HOLDOFF=5, ENABLE=0xFF, EVENT[2] held high (level), W1C 0x04 -> INTERRUPT low for 5 cycles after the load, then high again; HOLDOFF=0 repeat -> INTERRUPT never drops.
- Same-cycle W1C 0x02 and EVENT[1] edge -> STATUS bit 1 remains 1; same-cycle REG_RE and REG_WE to ENABLE (0 -> 0xAA) -> read returns 0, subsequent read returns 0xAA.
- With IRQ_CTRL_IRQ_COUNT_EN, produce 3 interrupt assertions -> address 4 reads 3; write address 4 -> reads 0; ARESETn pulsed mid-hold-off -> counter, STATUS and INTERRUPT all 0 immediately.
